// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the ALU shift blocks.
//   ALU_W       operand/result width
//   SHAMT_W     shift-amount width ($clog2(ALU_W))
//   shl_state_t control states of the sequential left shifter
package alu_pkg;

    localparam int ALU_W   = 32;
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shl_state_t;

endpackage

// File: rtl/shl_step.sv
// shl_step -- combinational single step of the sequential left shifter.
// Given the current accumulator and remaining count, produces the values
// after one SHIFT cycle.
// Build option: SHL_STEP4_EN -- when defined, a step shifts by 4 whenever at
// least 4 positions remain, otherwise by 1. When undefined, always by 1.
// Ports:
//   acc_i  in  WIDTH  current accumulator
//   cnt_i  in  SHW    remaining shift positions (>= 1 when used)
//   acc_o  out WIDTH  accumulator after this step
//   cnt_o  out SHW    remaining positions after this step
import alu_pkg::*;

module shl_step #(
    parameter int WIDTH = ALU_W,
    parameter int SHW   = SHAMT_W
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [SHW-1:0]   cnt_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [SHW-1:0]   cnt_o
);

`ifdef SHL_STEP4_EN
    always_comb begin
        if (cnt_i >= SHW'(4)) begin
            acc_o = acc_i << 4;
            cnt_o = cnt_i - SHW'(4);
        end else begin
            acc_o = acc_i << 1;
            cnt_o = cnt_i - SHW'(1);
        end
    end
`else
    assign acc_o = acc_i << 1;
    assign cnt_o = cnt_i - SHW'(1);
`endif

endmodule

// File: rtl/shift_left_seq.sv
// shift_left_seq -- multi-cycle logical left shifter (zero fill, no sign).
// A start pulse in IDLE captures A and B; the operand is shifted in SHIFT
// and the result is registered into out on the edge that enters DONE,
// where done pulses for one cycle.
// Build option: SHL_STEP4_EN (see shl_step) -- shortens latency only; the
// result is the same in both builds.
// Ports:
//   clk    in   1      clock, rising edge
//   rst_n  in   1      synchronous active-low reset
//   start  in   1      request, sampled only in IDLE
//   A      in   WIDTH  operand, captured on accepted start
//   B      in   SHW    shift amount, captured on accepted start
//   out    out  WIDTH  result; holds until the next DONE entry
//   busy   out  1      high in SHIFT and DONE
//   done   out  1      one-cycle completion pulse
import alu_pkg::*;

module shift_left_seq #(
    parameter int WIDTH = ALU_W,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   B,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    shl_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic [WIDTH-1:0] step_acc;
    logic [SHW-1:0]   step_cnt;

    shl_step #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_step (
        .acc_i (acc_q),
        .cnt_i (cnt_q),
        .acc_o (step_acc),
        .cnt_o (step_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = A;
                    cnt_d = B;
                    if (B == '0) begin
                        // Zero shift: result is the operand itself, go straight to DONE.
                        state_d = DONE;
                        out_d   = A;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_d = step_acc;
                cnt_d = step_cnt;
                // The step that exhausts the count also publishes the result.
                if (step_cnt == '0) begin
                    state_d = DONE;
                    out_d   = step_acc;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out  = out_q;
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_shift_left_seq.sv
// tb_shift_left_seq -- self-checking bench for shift_left_seq.
// Table of directed vectors, hand-written sequences for ignored start and
// mid-operation reset, then randomized operations against a reference model
// (A << B truncated, latency from the shift-amount rule). Honors SHL_STEP4_EN.
module tb_shift_left_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [4:0]  B;
    logic [31:0] dut_out;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;
    int done_count = 0;
    logic prev_done = 1'b0;

    shift_left_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .out   (dut_out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  b;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[8];

    // Reference: truncated logical shift.
    function automatic logic [31:0] ref_shl(input logic [31:0] a, input int b);
        logic [63:0] wide;
        wide = {32'd0, a} * (64'd1 << b);
        return wide[31:0];
    endfunction

    // Reference latency in edges from the start-sampling edge to the done cycle.
    function automatic int ref_lat(input int b);
        if (b == 0) return 1;
`ifdef SHL_STEP4_EN
        return 1 + b / 4 + b % 4;
`else
        return b + 1;
`endif
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Every done cycle: not two in a row, and busy accompanies done.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            checks++;
            if (prev_done === 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL done_pulse actual=prev%b_busy%b required=prev0_busy1", prev_done, busy);
            end
        end
        prev_done = done;
    end

    // Issue one operation and verify result, latency and return to idle.
    task automatic run_op(input logic [31:0] a, input logic [4:0] b, input logic [31:0] exp, input string name);
        int edges;
        logic busy_ok;
        busy_ok = 1'b1;
        A = a;
        B = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom;
        B = 5'($urandom);
        edges = 1;
        while (done !== 1'b1 && edges < 80) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            edges++;
        end
        if (done !== 1'b1) begin
            failures++;
            checks++;
            $display("FAIL %s_timeout actual=%0d required=%0d", name, edges, ref_lat(int'(b)));
        end else begin
            check32({name, "_lat"}, 32'(edges), 32'(ref_lat(int'(b))));
            check32({name, "_out"}, dut_out, exp);
            check32({name, "_busy"}, {31'd0, busy_ok}, 32'd1);
            $display("op %s A=%h B=%0d out=%h lat=%0d", name, a, b, dut_out, edges);
        end
        @(posedge clk); #1;
        check32({name, "_idle"}, {30'd0, busy, done}, 32'd0);
        check32({name, "_hold"}, dut_out, exp);
    endtask

    initial begin
        int edges;
        int cnt0;
        logic [31:0] ra;
        logic [4:0]  rb;

        vecs[0] = '{32'h0FFA05FF, 5'd10, 32'hE817FC00};
        vecs[1] = '{32'hDEADBEEF, 5'd0,  32'hDEADBEEF};
        vecs[2] = '{32'h00000001, 5'd31, 32'h80000000};
        vecs[3] = '{32'h0000000F, 5'd9,  32'h00001E00};
        vecs[4] = '{32'h80000001, 5'd1,  32'h00000002};
        vecs[5] = '{32'hA5A5A5A5, 5'd4,  32'h5A5A5A50};
        vecs[6] = '{32'hFFFFFFFF, 5'd3,  32'hFFFFFFF8};
        vecs[7] = '{32'h12345678, 5'd7,  32'h1A2B3C00};

        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (3) @(posedge clk);
        #1;
        check32("reset_state", {dut_out[31:0]}, 32'd0);
        check32("reset_flags", {30'd0, busy, done}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_out, $sformatf("vec%0d", i));
        end

        // start during SHIFT is ignored: single done, original result.
        cnt0 = done_count;
        A = 32'h000000FF;
        B = 5'd8;
        start = 1'b1;
        @(posedge clk); #1;
        A = 32'hFFFFFFFF;
        B = 5'd1;
        edges = 1;
        // Still asserted for the next edge, while the shifter is in SHIFT.
        @(posedge clk); #1;
        start = 1'b0;
        edges++;
        while (done !== 1'b1 && edges < 80) begin
            @(posedge clk); #1;
            edges++;
        end
        check32("ign_lat", 32'(edges), 32'(ref_lat(8)));
        check32("ign_out", dut_out, 32'h0000FF00);
        repeat (12) @(posedge clk);
        #1;
        check32("ign_single_done", 32'(done_count - cnt0), 32'd1);
        check32("ign_out_hold", dut_out, 32'h0000FF00);
        $display("op ignored_start out=%h lat=%0d", dut_out, edges);

        // Mid-operation reset discards the operation.
        cnt0 = done_count;
        A = 32'h12345678;
        B = 5'd20;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check32("rst_mid_out", dut_out, 32'd0);
        check32("rst_mid_flags", {30'd0, busy, done}, 32'd0);
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check32("rst_mid_no_done", 32'(done_count - cnt0), 32'd0);
        $display("op mid_reset out=%h busy=%b", dut_out, busy);
        run_op(32'h00000003, 5'd2, 32'h0000000C, "after_rst");

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = 5'($urandom_range(0, 31));
            run_op(ra, rb, ref_shl(ra, int'(rb)), $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
